// File: rtl/bitwise_gate_pipe_pkg.sv
// Shared constants for the pipelined bitwise gate bus: op-select codes and
// pipeline depth limits.
package bitwise_gate_pipe_pkg;

  localparam logic [2:0] MODE_NOT  = 3'b000;
  localparam logic [2:0] MODE_AND  = 3'b001;
  localparam logic [2:0] MODE_OR   = 3'b010;
  localparam logic [2:0] MODE_XOR  = 3'b011;
  localparam logic [2:0] MODE_NAND = 3'b100;
  localparam logic [2:0] MODE_NOR  = 3'b101;
  localparam logic [2:0] MODE_XNOR = 3'b110;
  localparam logic [2:0] MODE_PASS = 3'b111;

  localparam int unsigned MAX_STAGES = 4;
  // Occupancy must be able to represent 0..MAX_STAGES.
  localparam int unsigned OCC_W      = $clog2(MAX_STAGES + 1);

endpackage

// File: rtl/bitwise_gate_pipe_stage.sv
// One elastic register stage: holds a valid bit, a data word and its Zero flag.
// A stage can take a new item when it is empty or when its item is leaving.
module gate_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         up_valid_i,
  input  logic [W-1:0] up_data_i,
  input  logic         up_zero_i,
  input  logic         down_ready_i,
  output logic         up_ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         zero_o
);

  logic         v_q, v_d;
  logic [W-1:0] d_q, d_d;
  logic         z_q, z_d;
  logic         load;
  logic         leave;

  assign up_ready_o = ~v_q | down_ready_i;
  assign load       = up_valid_i & up_ready_o & ~flush_i;
  assign leave      = v_q & down_ready_i;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    z_d = z_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (load) begin
      v_d = 1'b1;
      d_d = up_data_i;
      z_d = up_zero_i;
    end else if (leave) begin
      v_d = 1'b0;
    end
  end

  // Zero resets to 1 so that the idle output reads Result=0, Zero=1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= 1'b0;
      d_q <= '0;
      z_q <= 1'b1;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      z_q <= z_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = d_q;
  assign zero_o  = z_q;

endmodule

// File: rtl/bitwise_gate_pipe.sv
// Multi-function bitwise gate feeding an elastic pipeline of NrOfStages stages.
// Handshake: a transfer happens on any edge where valid & ready are both high.
module bitwise_gate_pipe
  import bitwise_gate_pipe_pkg::*;
#(
  parameter int unsigned NrOfBits   = 8,
  parameter int unsigned NrOfStages = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Flush,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [NrOfBits-1:0] Input_1,
  input  logic [NrOfBits-1:0] Input_2,
  input  logic [2:0]          Mode,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [NrOfBits-1:0] Result,
  output logic                Zero,
  output logic [OCC_W-1:0]    Occupancy
);

  localparam int unsigned LAST = NrOfStages - 1;

  logic [NrOfBits-1:0] op_res;
  logic                op_zero;

  logic                v   [NrOfStages];
  logic [NrOfBits-1:0] d   [NrOfStages];
  logic                z   [NrOfStages];
  logic                rdy [NrOfStages];

  always_comb begin
    op_res = Input_1;
    unique case (Mode)
      MODE_NOT:  op_res = ~Input_1;
      MODE_AND:  op_res = Input_1 & Input_2;
      MODE_OR:   op_res = Input_1 | Input_2;
      MODE_XOR:  op_res = Input_1 ^ Input_2;
      MODE_NAND: op_res = ~(Input_1 & Input_2);
      MODE_NOR:  op_res = ~(Input_1 | Input_2);
      MODE_XNOR: op_res = ~(Input_1 ^ Input_2);
      MODE_PASS: op_res = Input_1;
      default:   op_res = Input_1;
    endcase
  end

  assign op_zero = (op_res == '0);

  for (genvar k = 0; k < NrOfStages; k++) begin : g_stage
    logic                up_valid;
    logic [NrOfBits-1:0] up_data;
    logic                up_zero;
    logic                down_ready;

    if (k == 0) begin : g_first
      assign up_valid = In_Valid;
      assign up_data  = op_res;
      assign up_zero  = op_zero;
    end else begin : g_mid
      assign up_valid = v[k-1];
      assign up_data  = d[k-1];
      assign up_zero  = z[k-1];
    end

    // Ready ripples back combinationally so a streaming pipe never bubbles.
    if (k == LAST) begin : g_tail
      assign down_ready = Out_Ready;
    end else begin : g_inner
      assign down_ready = rdy[k+1];
    end

    gate_pipe_stage #(
      .W(NrOfBits)
    ) u_stage (
      .clk_i       (Clock),
      .rst_i       (Reset),
      .flush_i     (Flush),
      .up_valid_i  (up_valid),
      .up_data_i   (up_data),
      .up_zero_i   (up_zero),
      .down_ready_i(down_ready),
      .up_ready_o  (rdy[k]),
      .valid_o     (v[k]),
      .data_o      (d[k]),
      .zero_o      (z[k])
    );
  end

  assign In_Ready  = rdy[0] & ~Flush;
  assign Out_Valid = v[LAST];
  assign Result    = d[LAST];
  assign Zero      = z[LAST];

  always_comb begin
    Occupancy = '0;
    for (int k = 0; k < NrOfStages; k++) begin
      Occupancy = Occupancy + OCC_W'(v[k]);
    end
  end

endmodule
